// File: rtl/core_pkg.sv
// Shared definitions for the integer register file and its writeback path.
//   XLEN       : register data width
//   REG_ADDR_W : register index width
//   NUM_REGS   : number of architectural integer registers
//   REG_ZERO   : index of the hardwired-zero register
package core_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // Which writeback source owns the register file port this cycle.
  typedef enum logic [1:0] {
    GrantNone,
    GrantLoad,
    GrantAlu
  } grant_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending scoreboard plus count of outstanding writes.
//   clock, reset_n       : clock, synchronous active-low reset
//   set_en, set_idx      : mark a destination pending (issue accept)
//   clr_en, clr_idx      : clear a pending destination (register file write)
//   query_rs1/rs2/rd/wb  : indices whose pending state is looked up
//   pend_rs1/rs2/rd/wb   : pending bit for each queried index
//   full                 : outstanding count has reached MAX_OUTSTANDING
module reg_scoreboard
  import core_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic      clock,
  input  logic      reset_n,
  input  logic      set_en,
  input  reg_addr_t set_idx,
  input  logic      clr_en,
  input  reg_addr_t clr_idx,
  input  reg_addr_t query_rs1,
  input  reg_addr_t query_rs2,
  input  reg_addr_t query_rd,
  input  reg_addr_t query_wb,
  output logic      pend_rs1,
  output logic      pend_rs2,
  output logic      pend_rd,
  output logic      pend_wb,
  output logic      full
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [CntW-1:0]     outstanding_q, outstanding_d;
  logic                do_set, do_clr;

  // r0 is never tracked, so its pending bit stays zero and queries on it
  // can never report a hazard.
  assign do_set = set_en && (set_idx != REG_ZERO);
  assign do_clr = clr_en && (clr_idx != REG_ZERO);

  always_comb begin
    pending_d = pending_q;
    if (do_clr) pending_d[clr_idx] = 1'b0;
    // Set after clear so a same-index collision leaves the bit set.
    if (do_set) pending_d[set_idx] = 1'b1;
  end

  always_comb begin
    outstanding_d = outstanding_q;
    unique case ({do_set, do_clr})
      2'b10:   outstanding_d = outstanding_q + CntW'(1);
      2'b01:   outstanding_d = outstanding_q - CntW'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pending_q     <= '0;
      outstanding_q <= '0;
    end else begin
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
    end
  end

  assign pend_rs1 = pending_q[query_rs1];
  assign pend_rs2 = pending_q[query_rs2];
  assign pend_rd  = pending_q[query_rd];
  assign pend_wb  = pending_q[query_wb];
  assign full     = (outstanding_q == CntW'(MAX_OUTSTANDING));

endmodule

// File: rtl/writeback_arbiter.sv
// Shares the single register file write port between the ALU and load
// writeback paths, and stalls decode on RAW/WAW hazards or too many
// outstanding writes.
//   clock, reset_n                      : clock, synchronous active-low reset
//   issue_valid/rs1/rs2/rd, issue_stall : decode handshake (stall is comb)
//   alu_valid/rd/data, alu_ready        : ALU writeback request / grant
//   load_valid/rd/data, load_ready      : load writeback request / grant
//   rd, data, reg_write                 : registered register file write
//   wb_error                            : sticky, write to a non-pending reg
module writeback_arbiter
  import core_pkg::*;
#(
  parameter int unsigned XLEN            = core_pkg::XLEN,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned MAX_WAIT        = 4
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rs1,
  input  logic [4:0]      issue_rs2,
  input  logic [4:0]      issue_rd,
  output logic            issue_stall,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            load_valid,
  input  logic [4:0]      load_rd,
  input  logic [XLEN-1:0] load_data,
  output logic            load_ready,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] data,
  output logic            reg_write,
  output logic            wb_error
);

  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

  logic            pend_rs1, pend_rs2, pend_rd, pend_wb, sb_full;
  logic            hazard, accept;
  grant_e          grant;
  reg_addr_t       grant_rd;
  logic [XLEN-1:0] grant_data;
  logic            alu_forced;

  logic [WaitW-1:0] wait_q, wait_d;
  reg_addr_t        rd_q, rd_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic             reg_write_q, reg_write_d;
  logic             wb_error_q, wb_error_d;

  reg_scoreboard #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_scoreboard (
    .clock     (clock),
    .reset_n   (reset_n),
    .set_en    (accept),
    .set_idx   (issue_rd),
    .clr_en    (reg_write_q),
    .clr_idx   (rd_q),
    .query_rs1 (issue_rs1),
    .query_rs2 (issue_rs2),
    .query_rd  (issue_rd),
    .query_wb  (grant_rd),
    .pend_rs1  (pend_rs1),
    .pend_rs2  (pend_rs2),
    .pend_rd   (pend_rd),
    .pend_wb   (pend_wb),
    .full      (sb_full)
  );

  // r0 never reads as pending, so the zero-index exclusions come for free.
  assign hazard      = pend_rs1 || pend_rs2 || pend_rd;
  assign issue_stall = issue_valid && (hazard || (sb_full && (issue_rd != REG_ZERO)));
  assign accept      = issue_valid && !issue_stall;

  assign alu_forced = (wait_q == WaitW'(MAX_WAIT));

  // Load has priority unless the ALU has been starved for MAX_WAIT cycles.
  always_comb begin
    grant = GrantNone;
    if (load_valid && !(alu_valid && alu_forced)) begin
      grant = GrantLoad;
    end else if (alu_valid) begin
      grant = GrantAlu;
    end
  end

  assign load_ready = (grant == GrantLoad);
  assign alu_ready  = (grant == GrantAlu);

  always_comb begin
    grant_rd   = REG_ZERO;
    grant_data = '0;
    unique case (grant)
      GrantLoad: begin
        grant_rd   = load_rd;
        grant_data = load_data;
      end
      GrantAlu: begin
        grant_rd   = alu_rd;
        grant_data = alu_data;
      end
      default: begin
        grant_rd   = REG_ZERO;
        grant_data = '0;
      end
    endcase
  end

  always_comb begin
    wait_d = '0;
    if (alu_valid && !alu_ready) begin
      wait_d = alu_forced ? wait_q : wait_q + WaitW'(1);
    end
  end

  // Writes to r0 are swallowed: no strobe and the held rd/data stay put.
  always_comb begin
    reg_write_d = (grant != GrantNone) && (grant_rd != REG_ZERO);
    rd_d        = reg_write_d ? grant_rd : rd_q;
    data_d      = reg_write_d ? grant_data : data_q;
    wb_error_d  = wb_error_q || (reg_write_d && !pend_wb);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wait_q      <= '0;
      rd_q        <= REG_ZERO;
      data_q      <= '0;
      reg_write_q <= 1'b0;
      wb_error_q  <= 1'b0;
    end else begin
      wait_q      <= wait_d;
      rd_q        <= rd_d;
      data_q      <= data_d;
      reg_write_q <= reg_write_d;
      wb_error_q  <= wb_error_d;
    end
  end

  assign rd        = rd_q;
  assign data      = data_q;
  assign reg_write = reg_write_q;
  assign wb_error  = wb_error_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed self-checking bench for writeback_arbiter.
module tb_writeback_arbiter;

  logic        clock;
  logic        reset_n;
  logic        issue_valid;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        issue_stall;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        load_valid;
  logic [4:0]  load_rd;
  logic [31:0] load_data;
  logic        load_ready;
  logic [4:0]  rd;
  logic [31:0] data;
  logic        reg_write;
  logic        wb_error;

  int vectors;
  int miscompares;

  writeback_arbiter #(
    .XLEN            (32),
    .MAX_OUTSTANDING (8),
    .MAX_WAIT        (4)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .issue_valid (issue_valid),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .issue_rd    (issue_rd),
    .issue_stall (issue_stall),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .alu_ready   (alu_ready),
    .load_valid  (load_valid),
    .load_rd     (load_rd),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .rd          (rd),
    .data        (data),
    .reg_write   (reg_write),
    .wb_error    (wb_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
    issue_valid = 1'b1;
    issue_rs1   = s1;
    issue_rs2   = s2;
    issue_rd    = d;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    issue_valid = 1'b0;
    issue_rs1   = '0;
    issue_rs2   = '0;
    issue_rd    = '0;
    alu_valid   = 1'b0;
    alu_rd      = '0;
    alu_data    = '0;
    load_valid  = 1'b0;
    load_rd     = '0;
    load_data   = '0;

    // Reset and idle
    tick();
    tick();
    chk("rst_reg_write", reg_write, 0);
    chk("rst_rd", rd, 0);
    chk("rst_data", data, 0);
    chk("rst_wb_error", wb_error, 0);
    reset_n = 1'b1;
    tick();
    chk("idle_reg_write", reg_write, 0);
    issue(1, 2, 3);
    #1 chk("idle_stall", issue_stall, 0);
    issue_valid = 1'b0;

    // Issue rd=5, ALU writes it back
    issue(0, 0, 5);
    #1 chk("iss5_stall", issue_stall, 0);
    tick();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5; alu_data = 32'h1234;
    #1 chk("alu5_ready", alu_ready, 1);
    chk("alu5_load_ready", load_ready, 0);
    tick();
    alu_valid = 1'b0;
    chk("wb5_reg_write", reg_write, 1);
    chk("wb5_rd", rd, 5);
    chk("wb5_data", data, 32'h1234);
    issue(5, 0, 0);
    #1 chk("raw5_in_write_cycle", issue_stall, 1);
    tick();
    chk("wb5_done_reg_write", reg_write, 0);
    chk("wb5_rd_hold", rd, 5);
    #1 chk("raw5_cleared", issue_stall, 0);
    issue_valid = 1'b0;

    // RAW on rd=7 stalls until the cycle after its write
    issue(0, 0, 7);
    tick();
    issue(7, 0, 10);
    #1 chk("raw7_stall_a", issue_stall, 1);
    tick();
    #1 chk("raw7_stall_b", issue_stall, 1);
    alu_valid = 1'b1; alu_rd = 7; alu_data = 32'h77;
    #1 chk("alu7_ready", alu_ready, 1);
    tick();
    alu_valid = 1'b0;
    chk("wb7_reg_write", reg_write, 1);
    chk("wb7_rd", rd, 7);
    #1 chk("raw7_stall_write_cycle", issue_stall, 1);
    tick();
    #1 chk("raw7_released", issue_stall, 0);
    tick();
    issue(0, 0, 0);
    #1 chk("r0_never_stalls", issue_stall, 0);
    tick();
    issue_valid = 1'b0;

    // Arbitration: load wins 4 times, then ALU is forced through
    for (int r = 13; r <= 18; r++) begin
      issue(0, 0, 5'(r));
      tick();
    end
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 17; alu_data = 32'hA;
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1; load_rd = 5'(13 + i); load_data = 32'hD00 + 32'(13 + i);
      #1 chk("arb_load_wins", load_ready, 1);
      chk("arb_alu_loses", alu_ready, 0);
      tick();
      chk("arb_load_wb_rd", rd, 32'(13 + i));
      chk("arb_load_wb_data", data, 32'hD00 + 32'(13 + i));
    end
    load_rd = 10; load_data = 32'hD10;
    #1 chk("arb_alu_forced", alu_ready, 1);
    chk("arb_load_held_off", load_ready, 0);
    tick();
    chk("arb_alu_wb_rd", rd, 17);
    chk("arb_alu_wb_data", data, 32'hA);
    alu_rd = 18; alu_data = 32'hB;
    #1 chk("arb_wait_cleared", load_ready, 1);
    tick();
    load_valid = 1'b0;
    #1 chk("arb_alu_alone", alu_ready, 1);
    tick();
    alu_valid = 1'b0;
    chk("arb_alu18_rd", rd, 18);
    tick();
    chk("arb_no_wb_error", wb_error, 0);

    // Outstanding limit
    for (int r = 1; r <= 8; r++) begin
      issue(0, 0, 5'(r));
      #1 chk("fill_accept", issue_stall, 0);
      tick();
    end
    issue(0, 0, 9);
    #1 chk("full_stall", issue_stall, 1);
    issue(20, 21, 0);
    #1 chk("full_rd0_ok", issue_stall, 0);
    issue(0, 0, 9);
    alu_valid = 1'b1; alu_rd = 1; alu_data = 32'h11;
    #1 chk("full_alu1_ready", alu_ready, 1);
    tick();
    alu_valid = 1'b0;
    chk("full_wb1_reg_write", reg_write, 1);
    #1 chk("full_stall_write_cycle", issue_stall, 1);
    tick();
    #1 chk("full_released", issue_stall, 0);
    tick();
    issue_valid = 1'b0;

    // Load to r0 and to a non-pending register
    load_valid = 1'b1; load_rd = 0; load_data = 32'h5;
    #1 chk("ld0_ready", load_ready, 1);
    tick();
    load_valid = 1'b0;
    chk("ld0_no_write", reg_write, 0);
    chk("ld0_no_error", wb_error, 0);
    load_valid = 1'b1; load_rd = 12; load_data = 32'hC;
    #1 chk("ld12_ready", load_ready, 1);
    tick();
    load_valid = 1'b0;
    chk("ld12_reg_write", reg_write, 1);
    chk("ld12_rd", rd, 12);
    chk("ld12_data", data, 32'hC);
    chk("ld12_wb_error", wb_error, 1);
    tick();
    chk("wb_error_sticky", wb_error, 1);
    chk("ld12_write_done", reg_write, 0);

    // Reset mid-transfer
    alu_valid = 1'b1; alu_rd = 2; alu_data = 32'h22;
    #1 chk("mid_alu_ready", alu_ready, 1);
    reset_n = 1'b0;
    tick();
    chk("mid_rst_reg_write", reg_write, 0);
    chk("mid_rst_rd", rd, 0);
    chk("mid_rst_data", data, 0);
    chk("mid_rst_wb_error", wb_error, 0);
    reset_n   = 1'b1;
    alu_valid = 1'b0;
    issue(3, 4, 9);
    #1 chk("mid_rst_scoreboard_clear", issue_stall, 0);
    issue_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
